// File: rtl/issue_ctrl.sv
// issue_ctrl: steps a halted core through ProgLen instructions with a Start/Go handshake per instruction.
// Define ISSUE_TIMEOUT_EN to build an 8-bit watchdog that aborts stuck handshakes and raises Err.
module issue_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Run,
  input  logic [4:0] ProgLen,
  input  logic       Ready,
  input  logic       Wen,
  output logic       Start,
  output logic       Go,
  output logic [4:0] PC,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_WB, SYNC, NEXT, FIN} state_t;
  state_t r_state, w_nxt;
  logic [4:0] r_len;
  logic w_to;
`ifdef ISSUE_TIMEOUT_EN
  logic [7:0] r_wd;
  logic w_wait;
  assign w_wait = r_state inside {ISSUE, WAIT_WB, SYNC};
  // Abort on the edge that would take the count to 255.
  assign w_to = w_wait && r_wd == 8'd254;
  always_ff @(posedge CLK)
    if (RST) begin
      r_wd <= 8'd0;
      Err  <= 1'b0;
    end else begin
      r_wd <= (w_nxt != r_state) ? 8'd0 : w_wait ? r_wd + 8'd1 : r_wd;
      Err  <= w_to | (Err & ~(r_state == IDLE && Run));
    end
`else
  assign w_to = 1'b0;
  assign Err  = 1'b0;
`endif
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (Run) w_nxt = (ProgLen == 5'd0) ? FIN : ISSUE;
      ISSUE:   if (!Ready) w_nxt = WAIT_WB;
      WAIT_WB: w_nxt = Ready ? IDLE : Wen ? SYNC : WAIT_WB;
      SYNC:    if (Ready) w_nxt = NEXT;
      NEXT:    w_nxt = (PC == r_len - 5'd1) ? FIN : ISSUE;
      FIN:     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
    if (w_to) w_nxt = IDLE;
  end
  always_ff @(posedge CLK)
    if (RST) r_state <= IDLE;
    else     r_state <= w_nxt;
  // Outputs are registered from the next state so Start follows Run by one cycle.
  always_ff @(posedge CLK)
    if (RST) begin
      Start <= 1'b0;
      Go    <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      PC    <= 5'd0;
      r_len <= 5'd0;
    end else begin
      Start <= w_nxt == ISSUE;
      Go    <= w_nxt == SYNC;
      Busy  <= w_nxt inside {ISSUE, WAIT_WB, SYNC, NEXT};
      Done  <= r_state == FIN;
      if (r_state == IDLE && Run) begin
        r_len <= ProgLen;
        PC    <= 5'd0;
      end else if (r_state == NEXT && w_nxt == ISSUE) PC <= PC + 5'd1;
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed bench for issue_ctrl driving a simple behavioural core.
module tb_issue_ctrl;
  logic CLK = 1'b0, RST = 1'b1, Run = 1'b0, Ready = 1'b1, Wen = 1'b0;
  logic [4:0] ProgLen = 5'd0;
  logic Start, Go, Busy, Done, Err;
  logic [4:0] PC;

  issue_ctrl dut (.CLK(CLK), .RST(RST), .Run(Run), .ProgLen(ProgLen), .Ready(Ready), .Wen(Wen),
                  .Start(Start), .Go(Go), .PC(PC), .Busy(Busy), .Done(Done), .Err(Err));

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;
  int n_start, n_go, n_done, n_both, max_pc;
  int pcs [32];
  logic p_start, p_go;
  logic core_en = 1'b0;
  int ph = 0, t = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_start = 0; n_go = 0; n_done = 0; n_both = 0; max_pc = 0;
    p_start = Start; p_go = Go;
    ph = 0; t = 0; Wen = 1'b0; Ready = 1'b1;
  endtask

  // One clock: observe outputs after the edge, then advance the core model.
  task automatic cyc();
    @(posedge CLK); #1;
    if (Start && Go) n_both++;
    if (Start && !p_start) begin
      if (n_start < 32) pcs[n_start] = int'(PC);
      n_start++;
    end
    if (Go && !p_go) n_go++;
    if (Done) n_done++;
    if (int'(PC) > max_pc) max_pc = int'(PC);
    p_start = Start; p_go = Go;
    if (core_en) begin
      Wen = 1'b0;
      if (ph == 0) begin
        if (Start) begin ph = 1; t = 2; end
      end else if (ph == 1) begin
        t = t - 1;
        if (t == 0) begin Ready = 1'b0; ph = 2; t = 3; end
      end else if (ph == 2) begin
        t = t - 1;
        if (t == 0) begin Wen = 1'b1; ph = 3; end
      end else if (ph == 3) begin
        if (Go) ph = 4;
      end else begin
        Ready = 1'b1; ph = 0;
      end
    end
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (!Done && n < lim) begin cyc(); n++; end
    check(tag, Done, 1);
  endtask

  task automatic run(input logic [4:0] len);
    Run = 1'b1; ProgLen = len;
    cyc();
    Run = 1'b0;
  endtask

  initial begin
    int n;
    cyc(); cyc();
    check("rst_start", Start, 0);
    check("rst_go", Go, 0);
    check("rst_pc", PC, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_err", Err, 0);
    RST = 1'b0;
    cyc();

    // ProgLen=3 with the core model; ProgLen changes after the latch
    clr(); core_en = 1'b1;
    run(5'd3);
    ProgLen = 5'd7;
    check("p3_start_lat", Start, 1);
    check("p3_busy", Busy, 1);
    wait_done("p3_done", 200);
    check("p3_busy_at_done", Busy, 0);
    cyc(); cyc(); cyc();
    check("p3_n_start", n_start, 3);
    check("p3_n_go", n_go, 3);
    check("p3_n_done", n_done, 1);
    check("p3_pc0", pcs[0], 0);
    check("p3_pc1", pcs[1], 1);
    check("p3_pc2", pcs[2], 2);
    check("p3_overlap", n_both, 0);
    check("p3_pc_hold", PC, 2);
    check("p3_busy_after", Busy, 0);

    // ProgLen=0: Done on the second edge, no Start
    clr(); core_en = 1'b0;
    run(5'd0);
    check("p0_done_e1", Done, 0);
    check("p0_pc", PC, 0);
    cyc();
    check("p0_done_e2", Done, 1);
    check("p0_busy", Busy, 0);
    cyc();
    check("p0_done_once", Done, 0);
    check("p0_n_start", n_start, 0);

    // ProgLen=2 with Run re-pulsed while busy
    clr(); core_en = 1'b1;
    run(5'd2);
    repeat (4) cyc();
    Run = 1'b1; ProgLen = 5'd5;
    cyc();
    Run = 1'b0;
    wait_done("p2_done", 200);
    cyc(); cyc();
    check("p2_n_start", n_start, 2);
    check("p2_n_done", n_done, 1);
    check("p2_pc", PC, 1);

    // Reset while in SYNC with PC=1
    clr(); core_en = 1'b1;
    run(5'd3);
    n = 0;
    while (!(Go && PC == 5'd1) && n < 200) begin cyc(); n++; end
    check("rs_reach_sync", int'(Go && PC == 5'd1), 1);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    check("rs_go", Go, 0);
    check("rs_pc", PC, 0);
    check("rs_busy", Busy, 0);
    check("rs_start", Start, 0);
    core_en = 1'b0; clr();
    repeat (5) cyc();
    check("rs_no_done", n_done, 0);
    check("rs_no_start", n_start, 0);

    // ProgLen=31
    clr(); core_en = 1'b1;
    run(5'd31);
    wait_done("p31_done", 2000);
    cyc(); cyc();
    check("p31_max_pc", max_pc, 30);
    check("p31_pc", PC, 30);
    check("p31_n_start", n_start, 31);
    check("p31_n_done", n_done, 1);

    // Core never drops Ready
    clr(); core_en = 1'b0;
    run(5'd1);
    check("to_start", Start, 1);
    n = 0;
    while (Start && n < 300) begin cyc(); n++; end
`ifdef ISSUE_TIMEOUT_EN
    check("to_start_cycles", n, 255);
    check("to_err", Err, 1);
    check("to_start_low", Start, 0);
    check("to_busy", Busy, 0);
    cyc(); cyc();
    check("to_no_done", n_done, 0);
    check("to_err_sticky", Err, 1);
    run(5'd0);
    check("to_err_clr", Err, 0);
    cyc(); cyc();
`else
    check("nto_start_cycles", n, 300);
    check("nto_err", Err, 0);
    check("nto_busy", Busy, 1);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    check("nto_rst_start", Start, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
